tx_symbol_scheduler: RTL and testbench

Symbol scheduler in front of the TX 8b/10b encoder. It decides which byte drives the encoder input (`TxParallel_8` with `TxDataK`) on every `BitCLK_10` edge. Sources are a link-alignment comma burst after reset or a retrain request, user bytes accepted over a valid/ready handshake, forced periodic K28.5 commas, and K28.5 idle fill. Illegal user control codes are replaced and flagged, so the encoder only ever sees legal K symbols.

---
 rtl/tx_symbol_scheduler.sv | 121 ++++++++++++
 tb/tb_tx_symbol_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_symbol_scheduler.sv
// rtl/tx_symbol_scheduler.sv - TX symbol scheduler feeding the 8b/10b encoder
// Picks alignment burst, forced comma, user byte or idle K28.5 on every BitCLK_10 edge.
`timescale 1ns/1ps

module tx_symbol_scheduler #(
  parameter int ALIGN_COUNT  = 16,
  parameter int COMMA_PERIOD = 64
) (
  input  logic       BitCLK_10,
  input  logic       Reset,
  input  logic [7:0] user_data,
  input  logic       user_k,
  input  logic       user_valid,
  output logic       user_ready,
  input  logic       train_req,
  output logic [7:0] TxParallel_8,
  output logic       TxDataK,
  output logic       link_ready,
  output logic       err_illegal_k
);

  localparam int AW = (ALIGN_COUNT > 1) ? $clog2(ALIGN_COUNT) : 1;
  localparam int CW = $clog2(COMMA_PERIOD);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_COUNT - 1);
  localparam logic [AW-1:0] ALIGN_ONE  = (ALIGN_COUNT > 1) ? AW'(1) : '0;
  localparam logic [CW-1:0] COMMA_LAST = CW'(COMMA_PERIOD - 1);
  localparam logic [7:0]    K28_5      = 8'hBC;
  localparam logic [7:0]    K30_7      = 8'hFE;

  typedef enum logic {ST_ALIGN, ST_DATA} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   align_cnt_q, align_cnt_d;
  logic [CW-1:0]   comp_cnt_q, comp_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_k_q, tx_k_d;
  logic            err_q, err_d;
  logic            insert_due;

  function automatic logic is_legal_k(input logic [7:0] b);
    logic legal;
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: legal = 1'b1;
      default:                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  always_ff @(posedge BitCLK_10 or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_ALIGN;
      align_cnt_q <= '0;
      comp_cnt_q  <= '0;
      tx_data_q   <= K28_5;
      tx_k_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      tx_data_q   <= tx_data_d;
      tx_k_q      <= tx_k_d;
      err_q       <= err_d;
    end
  end

  // Every non-user path emits K28.5, so that is the default symbol.
  always_comb begin
    state_d     = state_q;
    align_cnt_d = align_cnt_q;
    comp_cnt_d  = comp_cnt_q;
    tx_data_d   = K28_5;
    tx_k_d      = 1'b1;
    err_d       = 1'b0;
    case (state_q)
      ST_ALIGN: begin
        if (align_cnt_q == ALIGN_LAST) begin
          state_d     = ST_DATA;
          align_cnt_d = '0;
          comp_cnt_d  = '0;
        end else begin
          align_cnt_d = align_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (train_req) begin
          // The K28.5 emitted on this edge is the first symbol of the new burst.
          state_d     = ST_ALIGN;
          align_cnt_d = ALIGN_ONE;
          comp_cnt_d  = '0;
        end else if (insert_due) begin
          comp_cnt_d = '0;
        end else begin
          if (user_valid && user_ready) begin
            if (user_k && !is_legal_k(user_data)) begin
              tx_data_d = K30_7;
              tx_k_d    = 1'b1;
              err_d     = 1'b1;
            end else begin
              tx_data_d = user_data;
              tx_k_d    = user_k;
            end
          end
          comp_cnt_d = (tx_k_d && (tx_data_d == K28_5)) ? '0 : comp_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  always_comb begin
    insert_due    = (state_q == ST_DATA) && (comp_cnt_q == COMMA_LAST);
    user_ready    = (state_q == ST_DATA) && !insert_due && !train_req;
    link_ready    = (state_q == ST_DATA);
    TxParallel_8  = tx_data_q;
    TxDataK       = tx_k_q;
    err_illegal_k = err_q;
  end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// tb/tb_tx_symbol_scheduler.sv - directed self-checking bench for tx_symbol_scheduler
// Runs with ALIGN_COUNT=16 and COMMA_PERIOD=4; expected symbols are hand-computed.
`timescale 1ns/1ps

module tb_tx_symbol_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] user_data;
  logic       user_k;
  logic       user_valid;
  logic       user_ready;
  logic       train_req;
  logic [7:0] tx_data;
  logic       tx_k;
  logic       link_ready;
  logic       err_illegal_k;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] src_q[$];

  always #5 clk = ~clk;

  tx_symbol_scheduler #(.ALIGN_COUNT(16), .COMMA_PERIOD(4)) dut (
    .BitCLK_10    (clk),
    .Reset        (rst),
    .user_data    (user_data),
    .user_k       (user_k),
    .user_valid   (user_valid),
    .user_ready   (user_ready),
    .train_req    (train_req),
    .TxParallel_8 (tx_data),
    .TxDataK      (tx_k),
    .link_ready   (link_ready),
    .err_illegal_k(err_illegal_k)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic k, input logic [7:0] d);
    src_q.push_back({k, d});
  endtask

  task automatic drive_src();
    if (src_q.size() > 0) begin
      user_valid = 1'b1;
      {user_k, user_data} = src_q[0];
    end else begin
      user_valid = 1'b0;
      user_k     = 1'b0;
      user_data  = 8'h00;
    end
  endtask

  // One clock edge: the offered beat is taken if the handshake held before the edge.
  task automatic tick(input string tag, input logic [7:0] ed, input logic ek,
                      input logic eerr, input logic elr, input logic erdy);
    logic acc;
    acc = user_valid && user_ready;
    @(posedge clk);
    #1;
    if (acc) src_q.delete(0);
    drive_src();
    chk($sformatf("%s_data", tag), tx_data, ed);
    chk($sformatf("%s_k", tag), tx_k, ek);
    chk($sformatf("%s_err", tag), err_illegal_k, eerr);
    chk($sformatf("%s_link", tag), link_ready, elr);
    chk($sformatf("%s_rdy", tag), user_ready, erdy);
  endtask

  initial begin
    rst        = 1'b1;
    train_req  = 1'b0;
    user_valid = 1'b0;
    user_data  = 8'h00;
    user_k     = 1'b0;
    for (int i = 0; i < 12; i++) push(1'b0, 8'(i));
    drive_src();

    #12;
    chk("rst_data", tx_data, 8'hBC);
    chk("rst_k", tx_k, 1'b1);
    chk("rst_rdy", user_ready, 1'b0);
    chk("rst_link", link_ready, 1'b0);
    chk("rst_err", err_illegal_k, 1'b0);
    #10;
    rst = 1'b0;

    for (int e = 1; e <= 16; e++)
      tick($sformatf("align%0d", e), 8'hBC, 1'b1, 1'b0, e == 16, e == 16);

    tick("st00", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st01", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st02", 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("stc0", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("st03", 8'h03, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st04", 8'h04, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st05", 8'h05, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("stc1", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("st06", 8'h06, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st07", 8'h07, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st08", 8'h08, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("stc2", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("st09", 8'h09, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st0a", 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st0b", 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("stc3", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int e = 0; e < 4; e++)
      tick($sformatf("idle%0d", e), 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    push(1'b0, 8'h10); push(1'b0, 8'h11); push(1'b1, 8'hBC); push(1'b0, 8'h12);
    push(1'b0, 8'h13); push(1'b0, 8'h14); push(1'b0, 8'h15);
    drive_src();
    tick("uc_d0", 8'h10, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("uc_d1", 8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("uc_k", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("uc_d2", 8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("uc_d3", 8'h13, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("uc_d4", 8'h14, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("uc_fc", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("uc_d5", 8'h15, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("uc_idle", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    push(1'b0, 8'h20); push(1'b0, 8'h21); push(1'b0, 8'hBC);
    push(1'b0, 8'h22); push(1'b0, 8'h23);
    drive_src();
    tick("d28_d0", 8'h20, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("d28_d1", 8'h21, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("d28_bc", 8'hBC, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("d28_fc", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("d28_d2", 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("d28_d3", 8'h23, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("d28_idle", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    push(1'b1, 8'h00); push(1'b1, 8'h1C); push(1'b1, 8'h3D);
    drive_src();
    tick("ik_00", 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1);
    tick("ik_1c", 8'h1C, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("ik_3d", 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("ik_fc", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("ik_idle", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) push(1'b0, 8'(8'h30 + i));
    drive_src();
    tick("rt_d0", 8'h30, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rt_d1", 8'h31, 1'b0, 1'b0, 1'b1, 1'b1);
    train_req = 1'b1;
    #1;
    chk("rt_rdy_drop", user_ready, 1'b0);
    tick("rt_k0", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
    train_req = 1'b0;
    for (int e = 1; e <= 15; e++)
      tick($sformatf("rt_k%0d", e), 8'hBC, 1'b1, 1'b0, e == 15, e == 15);
    tick("rt_d2", 8'h32, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rt_d3", 8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rt_d4", 8'h34, 1'b0, 1'b0, 1'b1, 1'b0);
    tick("rt_fc", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("rt_d5", 8'h35, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rt_idle", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    train_req = 1'b1;
    for (int e = 1; e <= 16; e++)
      tick($sformatf("th_k%0d", e), 8'hBC, 1'b1, 1'b0, e == 16, 1'b0);
    tick("th_retrig", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
    train_req = 1'b0;
    for (int e = 1; e <= 15; e++)
      tick($sformatf("th_r%0d", e), 8'hBC, 1'b1, 1'b0, e == 15, e == 15);
    tick("th_idle", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) push(1'b0, 8'(8'h40 + i));
    drive_src();
    tick("ar_d0", 8'h40, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("ar_d1", 8'h41, 1'b0, 1'b0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_data", tx_data, 8'hBC);
    chk("ar_k", tx_k, 1'b1);
    chk("ar_rdy", user_ready, 1'b0);
    chk("ar_link", link_ready, 1'b0);
    chk("ar_err", err_illegal_k, 1'b0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++)
      tick($sformatf("ar_align%0d", e), 8'hBC, 1'b1, 1'b0, e == 16, e == 16);
    tick("ar_d2", 8'h42, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("ar_d3", 8'h43, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("ar_idle", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
